// File: rtl/motion_diff_engine.sv
// motion_diff_engine: compares a current-frame region against a reference
// region word by word and writes a per-byte motion mask to a destination region.
// A mask byte is 0xFF when the absolute byte difference exceeds the threshold.
// Optional feature macro: MOTION_DIFF_UPDATE_REF_EN -- after each mask write the
// current word is also copied into the reference region.
module motion_diff_engine (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  curBase,
  input  logic [8:0]  refBase,
  input  logic [8:0]  dstBase,
  input  logic [9:0]  wordCount,
  input  logic [7:0]  threshold,
  output logic [8:0]  memAddress,
  input  logic [31:0] memDataIn,
  output logic [31:0] memDataOut,
  output logic        memWriteEnable,
  output logic        busy,
  output logic        done,
  output logic [11:0] motionCount,
  output logic [4:0]  feedback
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_CUR = 3'd1,
    RD_REF = 3'd2,
    WR_DST = 3'd3,
    WR_REF = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  curBase_q, refBase_q, dstBase_q;
  logic [9:0]  wordCount_q;
  logic [7:0]  threshold_q;
  logic [8:0]  index_q, index_d;
  logic [31:0] curWord_q, curWord_d;
  logic [11:0] motionCount_q, motionCount_d;
  logic        doneSticky_q, doneSticky_d;
  logic [31:0] mask;
  logic [2:0]  hitCount;
  logic        lastWord;
  logic        writeRaw;

  // Per-byte absolute difference of latched current word vs incoming reference word
  always_comb begin
    mask     = '0;
    hitCount = '0;
    for (int k = 0; k < 4; k++) begin
      logic [8:0] diff;
      logic [8:0] absDiff;
      diff    = {1'b0, curWord_q[8*k +: 8]} - {1'b0, memDataIn[8*k +: 8]};
      absDiff = diff[8] ? ({1'b0, memDataIn[8*k +: 8]} - {1'b0, curWord_q[8*k +: 8]}) : diff;
      if (absDiff > {1'b0, threshold_q}) begin
        mask[8*k +: 8] = 8'hFF;
        hitCount       = hitCount + 3'd1;
      end
    end
  end

  assign lastWord = ({1'b0, index_q} == (wordCount_q - 10'd1));

  // Next-state logic and state-decoded memory/status outputs
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    curWord_d     = curWord_q;
    motionCount_d = motionCount_q;
    doneSticky_d  = doneSticky_q;
    memAddress    = '0;
    memDataOut    = '0;
    writeRaw      = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          motionCount_d = '0;
          index_d       = '0;
          doneSticky_d  = 1'b0;
          state_d       = (wordCount == 10'd0) ? DONE : RD_CUR;
        end
      end
      RD_CUR: begin
        busy       = 1'b1;
        memAddress = curBase_q + index_q;
        state_d    = RD_REF;
      end
      RD_REF: begin
        busy       = 1'b1;
        memAddress = refBase_q + index_q;
        curWord_d  = memDataIn;
        state_d    = WR_DST;
      end
      WR_DST: begin
        busy          = 1'b1;
        memAddress    = dstBase_q + index_q;
        memDataOut    = mask;
        writeRaw      = 1'b1;
        motionCount_d = motionCount_q + {9'd0, hitCount};
`ifdef MOTION_DIFF_UPDATE_REF_EN
        state_d       = WR_REF;
`else
        if (lastWord) begin
          state_d = DONE;
        end else begin
          index_d = index_q + 9'd1;
          state_d = RD_CUR;
        end
`endif
      end
      WR_REF: begin
`ifdef MOTION_DIFF_UPDATE_REF_EN
        busy       = 1'b1;
        memAddress = refBase_q + index_q;
        memDataOut = curWord_q;
        writeRaw   = 1'b1;
        if (lastWord) begin
          state_d = DONE;
        end else begin
          index_d = index_q + 9'd1;
          state_d = RD_CUR;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        done         = 1'b1;
        doneSticky_d = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A write requested in the same cycle as reset is suppressed so no partial job write lands
  assign memWriteEnable = writeRaw & ~reset;
  assign motionCount    = motionCount_q;
  assign feedback       = {doneSticky_q, busy, 3'(state_q)};

  // State, job configuration and accumulator registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      curBase_q     <= '0;
      refBase_q     <= '0;
      dstBase_q     <= '0;
      wordCount_q   <= '0;
      threshold_q   <= '0;
      index_q       <= '0;
      curWord_q     <= '0;
      motionCount_q <= '0;
      doneSticky_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      curWord_q     <= curWord_d;
      motionCount_q <= motionCount_d;
      doneSticky_q  <= doneSticky_d;
      if (state_q == IDLE && start) begin
        curBase_q   <= curBase;
        refBase_q   <= refBase;
        dstBase_q   <= dstBase;
        wordCount_q <= wordCount;
        threshold_q <= threshold;
      end
    end
  end

endmodule

// File: tb/tb_motion_diff_engine.sv
// Directed testbench for motion_diff_engine with a 512-word synchronous buffer memory.
// Expectations follow MOTION_DIFF_UPDATE_REF_EN when it is defined for the build.
module tb_motion_diff_engine;

`ifdef MOTION_DIFF_UPDATE_REF_EN
  localparam int PER_WORD = 4;
  localparam bit REF_UPD  = 1'b1;
`else
  localparam int PER_WORD = 3;
  localparam bit REF_UPD  = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  curBase = '0, refBase = '0, dstBase = '0;
  logic [9:0]  wordCount = '0;
  logic [7:0]  threshold = '0;
  logic [8:0]  memAddress;
  logic [31:0] memDataIn;
  logic [31:0] memDataOut;
  logic        memWriteEnable, busy, done;
  logic [11:0] motionCount;
  logic [4:0]  feedback;

  logic [31:0] mem [512];
  logic        loadEn = 1'b0;
  logic [8:0]  loadAddr = '0;
  logic [31:0] loadData = '0;
  logic        frozen = 1'b0;
  int          writeCount = 0, addr0Count = 0, addr511Count = 0;
  int          checks = 0, passes = 0;

  motion_diff_engine dut (
    .clock(clock), .reset(reset), .start(start),
    .curBase(curBase), .refBase(refBase), .dstBase(dstBase),
    .wordCount(wordCount), .threshold(threshold),
    .memAddress(memAddress), .memDataIn(memDataIn), .memDataOut(memDataOut),
    .memWriteEnable(memWriteEnable), .busy(busy), .done(done),
    .motionCount(motionCount), .feedback(feedback)
  );

  always #5 clock = ~clock;

  // Buffer memory: one-cycle read latency, bench preload port, write logging
  always @(posedge clock) begin
    memDataIn <= mem[memAddress];
    if (loadEn) mem[loadAddr] <= loadData;
    else if (memWriteEnable && !frozen) mem[memAddress] <= memDataOut;
    if (memWriteEnable) begin
      writeCount <= writeCount + 1;
      if (memAddress == 9'd0)   addr0Count   <= addr0Count + 1;
      if (memAddress == 9'd511) addr511Count <= addr511Count + 1;
    end
  end

  task automatic pokeWord(input logic [8:0] a, input logic [31:0] d);
    loadEn = 1'b1; loadAddr = a; loadData = d;
    @(negedge clock);
    loadEn = 1'b0;
  endtask

  task automatic runJob(input logic [8:0] c, input logic [8:0] r, input logic [8:0] d,
                        input logic [9:0] wc, input logic [7:0] th, input int bound,
                        output int latency, output int busyCycles);
    curBase = c; refBase = r; dstBase = d; wordCount = wc; threshold = th;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    latency = -1; busyCycles = 0;
    for (int n = 1; n <= bound; n++) begin
      if (done) begin latency = n; break; end
      if (busy) busyCycles++;
      @(negedge clock);
    end
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else passes++;
    checks++; if (memWriteEnable !== 1'b0) $display("[TB] FAIL reset_we got %b want 0", memWriteEnable); else passes++;
    checks++; if (memAddress !== 9'd0) $display("[TB] FAIL reset_addr got %0d want 0", memAddress); else passes++;
    checks++; if (memDataOut !== 32'd0) $display("[TB] FAIL reset_dout got %h want 0", memDataOut); else passes++;
    checks++; if (motionCount !== 12'd0) $display("[TB] FAIL reset_count got %0d want 0", motionCount); else passes++;
    checks++; if (feedback !== 5'd0) $display("[TB] FAIL reset_feedback got %b want 0", feedback); else passes++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_word;
    int lat, bc, w0;
    pokeWord(9'd10, 32'h10203040);
    pokeWord(9'd20, 32'h10203040);
    pokeWord(9'd30, 32'hDEADBEEF);
    w0 = writeCount;
    runJob(9'd10, 9'd20, 9'd30, 10'd1, 8'h00, 20, lat, bc);
    checks++; if (lat !== 1 + PER_WORD) $display("[TB] FAIL single_latency got %0d want %0d", lat, 1 + PER_WORD); else passes++;
    checks++; if (bc !== PER_WORD) $display("[TB] FAIL single_busy got %0d want %0d", bc, PER_WORD); else passes++;
    checks++; if (mem[30] !== 32'h0) $display("[TB] FAIL single_mask got %h want 00000000", mem[30]); else passes++;
    checks++; if (motionCount !== 12'd0) $display("[TB] FAIL single_count got %0d want 0", motionCount); else passes++;
    checks++; if (writeCount - w0 !== (REF_UPD ? 2 : 1)) $display("[TB] FAIL single_writes got %0d want %0d", writeCount - w0, REF_UPD ? 2 : 1); else passes++;
    checks++; if (feedback !== 5'b10000) $display("[TB] FAIL single_feedback got %b want 10000", feedback); else passes++;
  endtask

  task automatic test_threshold;
    int lat, bc;
    pokeWord(9'd50, 32'hFF008010);
    pokeWord(9'd51, 32'h00FF0550);
    pokeWord(9'd60, 32'h00007F10);
    pokeWord(9'd61, 32'hFF000560);
    pokeWord(9'd62, 32'hFF000560);
    runJob(9'd50, 9'd60, 9'd70, 10'd2, 8'h01, 40, lat, bc);
    checks++; if (mem[70] !== 32'hFF000000) $display("[TB] FAIL thr_mask0 got %h want FF000000", mem[70]); else passes++;
    checks++; if (mem[71] !== 32'hFFFF00FF) $display("[TB] FAIL thr_mask1 got %h want FFFF00FF", mem[71]); else passes++;
    checks++; if (motionCount !== 12'd4) $display("[TB] FAIL thr_count got %0d want 4", motionCount); else passes++;
    checks++; if (mem[60] !== (REF_UPD ? 32'hFF008010 : 32'h00007F10)) $display("[TB] FAIL ref_update got %h want %h", mem[60], REF_UPD ? 32'hFF008010 : 32'h00007F10); else passes++;
    runJob(9'd51, 9'd62, 9'd72, 10'd1, 8'h10, 20, lat, bc);
    checks++; if (mem[72] !== 32'hFFFF0000) $display("[TB] FAIL thr_equal got %h want FFFF0000", mem[72]); else passes++;
    checks++; if (motionCount !== 12'd2) $display("[TB] FAIL thr_count2 got %0d want 2", motionCount); else passes++;
  endtask

  task automatic test_zero_length;
    int lat, bc, w0;
    w0 = writeCount;
    runJob(9'd10, 9'd20, 9'd30, 10'd0, 8'h00, 10, lat, bc);
    checks++; if (lat !== 1) $display("[TB] FAIL zero_latency got %0d want 1", lat); else passes++;
    checks++; if (bc !== 0) $display("[TB] FAIL zero_busy got %0d want 0", bc); else passes++;
    checks++; if (writeCount - w0 !== 0) $display("[TB] FAIL zero_writes got %0d want 0", writeCount - w0); else passes++;
    checks++; if (motionCount !== 12'd0) $display("[TB] FAIL zero_count got %0d want 0", motionCount); else passes++;
  endtask

  task automatic test_ignored_start;
    int lat;
    pokeWord(9'd10, 32'h01020304);
    pokeWord(9'd11, 32'h01020304);
    pokeWord(9'd20, 32'h01020304);
    pokeWord(9'd21, 32'h01020305);
    pokeWord(9'd200, 32'hAAAAAAAA);
    pokeWord(9'd201, 32'hAAAAAAAA);
    pokeWord(9'd300, 32'h55555555);
    curBase = 9'd10; refBase = 9'd20; dstBase = 9'd200; wordCount = 10'd2; threshold = 8'h00;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin lat = n; break; end
      if (n == 2) begin
        dstBase = 9'd300; wordCount = 10'd0; threshold = 8'hFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    @(negedge clock);
    checks++; if (lat !== 1 + 2 * PER_WORD) $display("[TB] FAIL ign_latency got %0d want %0d", lat, 1 + 2 * PER_WORD); else passes++;
    checks++; if (mem[200] !== 32'h0) $display("[TB] FAIL ign_mask0 got %h want 00000000", mem[200]); else passes++;
    checks++; if (mem[201] !== 32'h000000FF) $display("[TB] FAIL ign_mask1 got %h want 000000FF", mem[201]); else passes++;
    checks++; if (mem[300] !== 32'h55555555) $display("[TB] FAIL ign_other_dst got %h want 55555555", mem[300]); else passes++;
    checks++; if (motionCount !== 12'd1) $display("[TB] FAIL ign_count got %0d want 1", motionCount); else passes++;
  endtask

  task automatic test_address_wrap;
    int lat, bc, w0, a0, a511;
    for (int i = 0; i < 512; i++) pokeWord(9'(i), (i % 2 == 0) ? 32'hFFFFFFFF : 32'h0);
    frozen = 1'b1;
    w0 = writeCount; a0 = addr0Count; a511 = addr511Count;
    runJob(9'd0, 9'd1, 9'd256, 10'd512, 8'h7F, 3000, lat, bc);
    frozen = 1'b0;
    checks++; if (lat !== 1 + 512 * PER_WORD) $display("[TB] FAIL wrap_latency got %0d want %0d", lat, 1 + 512 * PER_WORD); else passes++;
    checks++; if (bc !== 512 * PER_WORD) $display("[TB] FAIL wrap_busy got %0d want %0d", bc, 512 * PER_WORD); else passes++;
    checks++; if (motionCount !== 12'h800) $display("[TB] FAIL wrap_count got %h want 800", motionCount); else passes++;
    checks++; if (writeCount - w0 !== (REF_UPD ? 1024 : 512)) $display("[TB] FAIL wrap_writes got %0d want %0d", writeCount - w0, REF_UPD ? 1024 : 512); else passes++;
    checks++; if (addr0Count - a0 !== (REF_UPD ? 2 : 1)) $display("[TB] FAIL wrap_addr0 got %0d want %0d", addr0Count - a0, REF_UPD ? 2 : 1); else passes++;
    checks++; if (addr511Count - a511 !== (REF_UPD ? 2 : 1)) $display("[TB] FAIL wrap_addr511 got %0d want %0d", addr511Count - a511, REF_UPD ? 2 : 1); else passes++;
  endtask

  task automatic test_reset_midjob;
    bit found;
    for (int i = 0; i < 5; i++) begin
      pokeWord(9'(40 + i), 32'hFFFFFFFF);
      pokeWord(9'(60 + i), 32'h0);
    end
    pokeWord(9'd103, 32'h12345678);
    curBase = 9'd40; refBase = 9'd60; dstBase = 9'd100; wordCount = 10'd5; threshold = 8'h00;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (memWriteEnable && memAddress == 9'd103) begin found = 1'b1; break; end
      @(negedge clock);
    end
    checks++; if (found !== 1'b1) $display("[TB] FAIL mid_reach_word3 got %b want 1", found); else passes++;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy got %b want 0", busy); else passes++;
    checks++; if (memWriteEnable !== 1'b0) $display("[TB] FAIL mid_we got %b want 0", memWriteEnable); else passes++;
    checks++; if (motionCount !== 12'd0) $display("[TB] FAIL mid_count got %0d want 0", motionCount); else passes++;
    checks++; if (feedback !== 5'd0) $display("[TB] FAIL mid_feedback got %b want 0", feedback); else passes++;
    checks++; if (mem[103] !== 32'h12345678) $display("[TB] FAIL mid_no_write got %h want 12345678", mem[103]); else passes++;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL mid_stays_idle got %b want 0", busy); else passes++;
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_single_word();
    test_threshold();
    test_zero_length();
    test_ignored_start();
    test_address_wrap();
    test_reset_midjob();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
